// File: rtl/execute_pkg.sv
// Shared types and encodings for the RV32M execute stage.
package execute_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Remainder ops take the dividend's sign; all others the XOR of operand signs.
    function automatic logic md_result_neg(input md_op_t op, input logic a_neg, input logic b_neg);
        return (op == REM || op == REMU) ? a_neg : (a_neg ^ b_neg);
    endfunction

endpackage

// File: rtl/alu.sv
// RV32I integer ALU used by the execute stage.
module alu
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [3:0]            ctrl_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SLT:   result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_SLL:   result_o = a_i << shamt;
            ALU_SRL:   result_o = a_i >> shamt;
            ALU_SRA:   result_o = $signed(a_i) >>> shamt;
            ALU_PASSB: result_o = b_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide engine with sign fix-up.
// EXECUTE_MD_FASTMUL_EN makes multiplies single-cycle combinational; divides still iterate.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
);

    localparam int MD_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int W2       = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONES    = '1;
    localparam logic [MD_CNT_W-1:0]   LAST    = MD_CNT_W'(DATA_WIDTH - 1);

    md_state_t             state_q;
    logic [MD_CNT_W-1:0]   cnt_q;
    md_op_t                op_q;
    logic [DATA_WIDTH-1:0] opnd_q;
    logic [W2-1:0]         acc_q;
    logic                  neg_q;

    md_op_t                op_in;
    logic                  a_signed, b_signed, a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic                  div_zero, div_ovf, is_fast, launch;
    logic [DATA_WIDTH:0]   mul_sum, div_trial;
    logic [W2-1:0]         step_acc, prod_fix;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix, eng_res, fast_res;

    assign op_in = md_op_t'(op_i);

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_in)
            MULH, DIV, REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MULHSU:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg    = a_signed & src_a_i[DATA_WIDTH-1];
    assign b_neg    = b_signed & src_b_i[DATA_WIDTH-1];
    assign a_mag    = a_neg ? -src_a_i : src_a_i;
    assign b_mag    = b_neg ? -src_b_i : src_b_i;
    assign div_zero = op_in[2] && (src_b_i == '0);
    assign div_ovf  = (op_in == DIV || op_in == REM) && (src_a_i == MIN_VAL) && (src_b_i == ONES);

`ifdef EXECUTE_MD_FASTMUL_EN
    logic [W2-1:0] fast_prod;
    assign is_fast   = ~op_in[2];
    assign fast_prod = {{DATA_WIDTH{a_neg}}, src_a_i} * {{DATA_WIDTH{b_neg}}, src_b_i};
    assign fast_res  = (op_in == MUL) ? fast_prod[DATA_WIDTH-1:0] : fast_prod[W2-1:DATA_WIDTH];
`else
    assign is_fast  = 1'b0;
    assign fast_res = '0;
`endif

    assign launch = start_i & ~flush_i & ~rst & ~is_fast & (state_q == IDLE);
    assign busy_o = launch | ((state_q == BUSY) & ~flush_i & ~rst);

    // One radix-2 step: acc is {hi, lo}; multiply shifts the partial sum right,
    // divide shifts the remainder/quotient pair left with a restoring trial subtract.
    assign mul_sum   = {1'b0, acc_q[W2-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = acc_q[W2-1:DATA_WIDTH-1] - {1'b0, opnd_q};

    always_comb begin
        if (op_q[2]) begin
            if (!div_trial[DATA_WIDTH]) begin
                step_acc = {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {acc_q[W2-2:0], 1'b0};
            end
        end else begin
            step_acc = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MUL;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        op_q  <= op_in;
                        cnt_q <= '0;
                        if (div_zero) begin
                            acc_q   <= {src_a_i, ONES};
                            neg_q   <= 1'b0;
                            state_q <= DONE;
                        end else if (div_ovf) begin
                            acc_q   <= {{DATA_WIDTH{1'b0}}, MIN_VAL};
                            neg_q   <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            opnd_q  <= op_in[2] ? b_mag : a_mag;
                            acc_q   <= {{DATA_WIDTH{1'b0}}, op_in[2] ? a_mag : b_mag};
                            neg_q   <= md_result_neg(op_in, a_neg, b_neg);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    assign rem_fix  = neg_q ? -acc_q[W2-1:DATA_WIDTH] : acc_q[W2-1:DATA_WIDTH];

    always_comb begin
        case (op_q)
            MUL:                 eng_res = prod_fix[DATA_WIDTH-1:0];
            MULH, MULHSU, MULHU: eng_res = prod_fix[W2-1:DATA_WIDTH];
            DIV, DIVU:           eng_res = quo_fix;
            default:             eng_res = rem_fix;
        endcase
    end

    always_comb begin
        if (state_q == DONE) begin
            result_o = eng_res;
        end else if (start_i && is_fast) begin
            result_o = fast_res;
        end else begin
            result_o = '0;
        end
    end

endmodule

// File: rtl/execute_md.sv
// RV32IM execute stage: forwarding, ALU, branch/jump resolution and the mul/div engine.
module execute_md
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RD1E_i,
    input  logic [DATA_WIDTH-1:0] RD2E_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] ImmExtE_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
    input  logic [4:0]            RdE_i,
    input  logic [4:0]            Rs1E_i,
    input  logic [4:0]            Rs2E_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [1:0]            ForwardAE_i,
    input  logic [1:0]            ForwardBE_i,
    input  logic                  RegWriteE_i,
    input  logic                  MemWriteE_i,
    input  logic                  JumpE_i,
    input  logic                  BranchE_i,
    input  logic                  ALUSrcE_i,
    input  logic [2:0]            BranchSrcE_i,
    input  logic [3:0]            ALUCtrlE_i,
    input  logic                  MulDivE_i,
    input  logic [2:0]            MulDivOpE_i,
    input  logic                  FlushE_i,
    output logic [DATA_WIDTH-1:0] ALUResultE_o,
    output logic [DATA_WIDTH-1:0] WriteDataE_o,
    output logic [DATA_WIDTH-1:0] PCTargetE_o,
    output logic [DATA_WIDTH-1:0] PCPlus4E_o,
    output logic [4:0]            RdE_o,
    output logic [4:0]            Rs1E_o,
    output logic [4:0]            Rs2E_o,
    output logic                  branchTaken_o,
    output logic                  PCSrcE_o,
    output logic                  StallMD_o
);

    logic [DATA_WIDTH-1:0] src_a, src_b, alu_result, md_result;
    logic                  br_eq, br_lt, br_ltu;
    logic                  unused_ctrl;

    // Write-back/store enables travel on through the EX/MEM register, not used here.
    assign unused_ctrl = RegWriteE_i ^ MemWriteE_i;

    always_comb begin
        case (ForwardAE_i)
            FWD_WB:  src_a = ResultW_i;
            FWD_MEM: src_a = ALUResultM_i;
            default: src_a = RD1E_i;
        endcase
        case (ForwardBE_i)
            FWD_WB:  WriteDataE_o = ResultW_i;
            FWD_MEM: WriteDataE_o = ALUResultM_i;
            default: WriteDataE_o = RD2E_i;
        endcase
    end

    assign src_b = ALUSrcE_i ? ImmExtE_i : WriteDataE_o;

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a_i     (src_a),
        .b_i     (src_b),
        .ctrl_i  (ALUCtrlE_i),
        .result_o(alu_result)
    );

    muldiv_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (MulDivE_i),
        .flush_i (FlushE_i),
        .op_i    (MulDivOpE_i),
        .src_a_i (src_a),
        .src_b_i (WriteDataE_o),
        .result_o(md_result),
        .busy_o  (StallMD_o)
    );

    assign br_eq  = (src_a == WriteDataE_o);
    assign br_lt  = ($signed(src_a) < $signed(WriteDataE_o));
    assign br_ltu = (src_a < WriteDataE_o);

    always_comb begin
        case (BranchSrcE_i)
            BR_EQ:   branchTaken_o = br_eq;
            BR_NE:   branchTaken_o = ~br_eq;
            BR_LT:   branchTaken_o = br_lt;
            BR_GE:   branchTaken_o = ~br_lt;
            BR_LTU:  branchTaken_o = br_ltu;
            BR_GEU:  branchTaken_o = ~br_ltu;
            default: branchTaken_o = 1'b0;
        endcase
    end

    assign PCTargetE_o  = JumpE_i ? alu_result : (PCE_i + ImmExtE_i);
    assign PCSrcE_o     = (BranchE_i & branchTaken_o) | JumpE_i;
    assign ALUResultE_o = MulDivE_i ? md_result : alu_result;
    assign PCPlus4E_o   = PCPlus4E_i;
    assign RdE_o        = RdE_i;
    assign Rs1E_o       = Rs1E_i;
    assign Rs2E_o       = Rs2E_i;

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: directed mul/div vectors, forwarding, flush and reset.
module tb_execute_md;
    import execute_pkg::*;

    localparam int DW = 32;
`ifdef EXECUTE_MD_FASTMUL_EN
    localparam int MUL_ST = 0;
`else
    localparam int MUL_ST = DW + 1;
`endif
    localparam int DIV_ST = DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] RD1E_i, RD2E_i, PCE_i, ImmExtE_i, PCPlus4E_i, ResultW_i, ALUResultM_i;
    logic [4:0]    RdE_i, Rs1E_i, Rs2E_i;
    logic [1:0]    ForwardAE_i, ForwardBE_i;
    logic          RegWriteE_i, MemWriteE_i, JumpE_i, BranchE_i, ALUSrcE_i, MulDivE_i, FlushE_i;
    logic [2:0]    BranchSrcE_i, MulDivOpE_i;
    logic [3:0]    ALUCtrlE_i;
    logic [DW-1:0] ALUResultE_o, WriteDataE_o, PCTargetE_o, PCPlus4E_o;
    logic [4:0]    RdE_o, Rs1E_o, Rs2E_o;
    logic          branchTaken_o, PCSrcE_o, StallMD_o;

    always #5 clk = ~clk;

    execute_md #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .RD1E_i(RD1E_i), .RD2E_i(RD2E_i), .PCE_i(PCE_i), .ImmExtE_i(ImmExtE_i),
        .PCPlus4E_i(PCPlus4E_i), .RdE_i(RdE_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
        .ResultW_i(ResultW_i), .ALUResultM_i(ALUResultM_i),
        .ForwardAE_i(ForwardAE_i), .ForwardBE_i(ForwardBE_i),
        .RegWriteE_i(RegWriteE_i), .MemWriteE_i(MemWriteE_i), .JumpE_i(JumpE_i),
        .BranchE_i(BranchE_i), .ALUSrcE_i(ALUSrcE_i), .BranchSrcE_i(BranchSrcE_i),
        .ALUCtrlE_i(ALUCtrlE_i), .MulDivE_i(MulDivE_i), .MulDivOpE_i(MulDivOpE_i),
        .FlushE_i(FlushE_i),
        .ALUResultE_o(ALUResultE_o), .WriteDataE_o(WriteDataE_o), .PCTargetE_o(PCTargetE_o),
        .PCPlus4E_o(PCPlus4E_o), .RdE_o(RdE_o), .Rs1E_o(Rs1E_o), .Rs2E_o(Rs2E_o),
        .branchTaken_o(branchTaken_o), .PCSrcE_o(PCSrcE_o), .StallMD_o(StallMD_o)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] val;
        int            stalls;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a result is presented when an M op is in EX and the stage is not stalled.
    always @(negedge clk) begin
        if (rst || FlushE_i || !MulDivE_i) begin
            stall_cnt = 0;
        end else if (StallMD_o) begin
            stall_cnt++;
        end else begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h want none", ALUResultE_o);
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.name, ALUResultE_o, mon_e.val);
                check({mon_e.name, "_stalls"}, DW'(stall_cnt), DW'(mon_e.stalls));
            end
            stall_cnt = 0;
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (StallMD_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (StallMD_o) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: stall still high, want low", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic md_run(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp, input int stalls);
        exp_t e;
        e.name   = name;
        e.val    = exp;
        e.stalls = stalls;
        sb_q.push_back(e);
        ForwardAE_i = 2'b00;
        ForwardBE_i = 2'b00;
        MulDivE_i   = 1'b1;
        MulDivOpE_i = op;
        RD1E_i      = a;
        RD2E_i      = b;
        wait_done(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        RD1E_i = '0; RD2E_i = '0; PCE_i = '0; ImmExtE_i = '0; PCPlus4E_i = '0;
        ResultW_i = '0; ALUResultM_i = '0; RdE_i = '0; Rs1E_i = '0; Rs2E_i = '0;
        ForwardAE_i = '0; ForwardBE_i = '0; RegWriteE_i = 1'b0; MemWriteE_i = 1'b0;
        JumpE_i = 1'b0; BranchE_i = 1'b0; ALUSrcE_i = 1'b0; BranchSrcE_i = '0;
        ALUCtrlE_i = ALU_ADD; MulDivE_i = 1'b1; MulDivOpE_i = DIV; FlushE_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", DW'(StallMD_o), 0);
        @(negedge clk);
        check("reset_stall_hold", DW'(StallMD_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        MulDivE_i = 1'b0;

        // Forwarding and branch resolution.
        RD1E_i = 32'h99; RD2E_i = 32'h10; ALUResultM_i = 32'h10; ForwardAE_i = 2'b10;
        BranchE_i = 1'b1; BranchSrcE_i = BR_EQ; PCE_i = 32'h100; ImmExtE_i = 32'h20;
        PCPlus4E_i = 32'h104; RdE_i = 5'd7; Rs1E_i = 5'd3; Rs2E_i = 5'd9;
        @(negedge clk);
        check("beq_taken", DW'(branchTaken_o), 1);
        check("beq_pcsrc", DW'(PCSrcE_o), 1);
        check("beq_nostall", DW'(StallMD_o), 0);
        check("beq_target", PCTargetE_o, 32'h120);
        check("pcplus4", PCPlus4E_o, 32'h104);
        check("rd_pass", DW'({Rs2E_o, Rs1E_o, RdE_o}), DW'({5'd9, 5'd3, 5'd7}));

        ForwardAE_i = 2'b01; ResultW_i = 32'd5; RD2E_i = 32'hFFFF_FFFF; BranchSrcE_i = BR_LT;
        @(negedge clk);
        check("blt_not_taken", DW'(branchTaken_o), 0);
        check("blt_pcsrc", DW'(PCSrcE_o), 0);
        BranchSrcE_i = BR_LTU;
        @(negedge clk);
        check("bltu_taken", DW'(branchTaken_o), 1);

        BranchE_i = 1'b0; ForwardAE_i = 2'b00; RD1E_i = 32'h100; ALUSrcE_i = 1'b1;
        ALUCtrlE_i = ALU_ADD; ImmExtE_i = 32'h20; JumpE_i = 1'b1; RD2E_i = 32'h55;
        @(negedge clk);
        check("jalr_result", ALUResultE_o, 32'h120);
        check("jalr_target", PCTargetE_o, 32'h120);
        check("jalr_pcsrc", DW'(PCSrcE_o), 1);
        check("wdata_rf", WriteDataE_o, 32'h55);

        JumpE_i = 1'b0; ALUSrcE_i = 1'b0; ALUCtrlE_i = ALU_SUB; RD1E_i = 32'd10;
        ForwardBE_i = 2'b10; ALUResultM_i = 32'd3;
        @(negedge clk);
        check("sub_fwd_mem", ALUResultE_o, 32'd7);
        check("wdata_fwd_mem", WriteDataE_o, 32'd3);

        // Mul/div vectors, issued back to back.
        @(posedge clk);
        #1;
        md_run("mul_7_m3",   MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_ST);
        md_run("mulh_min",   MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_ST);
        md_run("mulhsu_m1",  MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_ST);
        md_run("div_m7_2",   DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_ST);
        md_run("rem_m7_2",   REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_ST);
        md_run("div_7_m2",   DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_ST);
        md_run("rem_7_m2",   REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_ST);
        md_run("divu_big",   DIVU,   32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, DIV_ST);
        md_run("remu_big",   REMU,   32'hFFFF_FFFF,  32'h10,        32'hF,         DIV_ST);
        md_run("div_by0",    DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        md_run("rem_by0",    REM,    32'd5,          32'd0,         32'd5,         1);
        md_run("divu_by0",   DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        md_run("div_ovf",    DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        md_run("rem_ovf",    REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Forwarded operands are latched: changing them mid-operation has no effect.
        e.name = "mul_fwd_latch";
        e.val = 32'd30;
        e.stalls = MUL_ST;
        sb_q.push_back(e);
        ForwardAE_i = 2'b01; ResultW_i = 32'd6; ForwardBE_i = 2'b10; ALUResultM_i = 32'd5;
        RD1E_i = 32'd1000; RD2E_i = 32'd1000; MulDivOpE_i = MUL; MulDivE_i = 1'b1;
`ifdef EXECUTE_MD_FASTMUL_EN
        wait_done("mul_fwd_latch");
`else
        @(posedge clk);
        #1;
        ResultW_i = 32'd99; ALUResultM_i = 32'd77;
        wait_done("mul_fwd_latch");
`endif
        MulDivE_i = 1'b0;
        @(posedge clk);
        #1;

        // Flush in the 10th BUSY cycle.
        ForwardAE_i = 2'b00; ForwardBE_i = 2'b00; RD1E_i = 32'd1000; RD2E_i = 32'd3;
        MulDivOpE_i = DIV; MulDivE_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("busy_stall", DW'(StallMD_o), 1);
        FlushE_i = 1'b1;
        @(negedge clk);
        check("flush_stall", DW'(StallMD_o), 0);
        @(posedge clk);
        #1;
        FlushE_i = 1'b0;
        MulDivE_i = 1'b0;
        @(posedge clk);
        #1;
        md_run("divu_after_flush", DIVU, 32'd100, 32'd7, 32'd14, DIV_ST);

        // Reset in mid-BUSY.
        RD1E_i = 32'd1000; RD2E_i = 32'd3; MulDivOpE_i = DIVU; MulDivE_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        MulDivE_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_stall", DW'(StallMD_o), 0);
        @(posedge clk);
        #1;
        md_run("mulhu_ff_2", MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, MUL_ST);
        MulDivE_i = 1'b0;

        repeat (3) @(posedge clk);
        check("scoreboard_empty", DW'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised successor execute stage for the 5-stage RV32 pipeline, extended with RV32M multiply/divide.
- Keeps the existing datapath:
  - operand forwarding muxes;
  - ALU instance;
  - branch/jump resolution;
  - PC target generation.
- Adds an iterative mul/div engine that stalls the pipeline through the hazard unit while it runs.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- DATA_WIDTH, 32, datapath width; must be even and ≥8.
- MD_CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width (localparam, derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RD1E_i, RD2E_i  in  DATA_WIDTH  register file operands
- PCE_i, ImmExtE_i, PCPlus4E_i  in  DATA_WIDTH  PC, extended immediate, PC+4
- RdE_i, Rs1E_i, Rs2E_i  in  5  destination and source register indices
- ResultW_i, ALUResultM_i  in  DATA_WIDTH  forwarding sources
- ForwardAE_i, ForwardBE_i  in  2  forwarding selects: 00 register file, 01 WB, 10 MEM, 11 register file
- RegWriteE_i, MemWriteE_i, JumpE_i, BranchE_i, ALUSrcE_i  in  1  control bits
- BranchSrcE_i  in  3  branch comparison select
- ALUCtrlE_i  in  4  ALU operation
- MulDivE_i  in  1  current instruction is RV32M
- MulDivOpE_i  in  3  funct3 of the RV32M instruction
- FlushE_i  in  1  hazard-unit flush of the EX stage
- ALUResultE_o, WriteDataE_o, PCTargetE_o, PCPlus4E_o  out  DATA_WIDTH  stage results
- RdE_o, Rs1E_o, Rs2E_o  out  5  pass-through indices
- branchTaken_o, PCSrcE_o  out  1  branch outcome and PC redirect
- StallMD_o  out  1  asserted while the mul/div result is not ready

Behaviour:
- Non-M instructions: purely combinational, identical to the existing execute stage.
  - SrcAE and WriteDataE_o come from the forwarding muxes.
  - SrcBE = ALUSrcE_i ? ImmExtE_i : WriteDataE_o.
  - PCTargetE_o = JumpE_i ? ALU result : PCE_i + ImmExtE_i.
  - PCSrcE_o = (BranchE_i & branchTaken_o) | JumpE_i.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - MulDivE_i=1 and FlushE_i=0: latch forwarded SrcAE, WriteDataE_o and the op; StallMD_o=1 combinationally in this same cycle; next state BUSY.
  - Special cases go straight to DONE instead of BUSY (StallMD_o=1 for one cycle only):
    - divide by zero: quotient all-ones, remainder = dividend;
    - signed overflow MIN/−1: quotient MIN, remainder 0.
- BUSY:
  - One radix-2 step per cycle on magnitudes: shift-add for multiply, restoring division for divide.
  - Counter runs DATA_WIDTH steps, then DONE.
  - StallMD_o=1 throughout.
- DONE:
  - StallMD_o=0 and ALUResultE_o = fixed-up result, so the EX/MEM register captures it.
  - Next state is always IDLE; a back-to-back M instruction restarts on the following cycle.
- Normal-path latency: StallMD_o is high for DATA_WIDTH+1 cycles and the result appears in the cycle after that.
- Sign fix-up:
  - MUL: low half of the product.
  - MULH: signed × signed; MULHSU: signed × unsigned; MULHU: unsigned × unsigned. Each returns the high half.
  - The 2×DATA_WIDTH product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
- Operands are latched, so forwarding values changing during the stall have no effect.
- FlushE_i in any state: next state IDLE and StallMD_o=0 in that cycle; the engine result is discarded.
- rst: state IDLE, counter 0, all operand/accumulator registers 0, StallMD_o=0. Other outputs follow their inputs combinationally.
- During an M operation, ALUResultE_o and the ALU inputs are don't-care except in DONE; PCSrcE_o is 0 (M instructions are never branch/jump).

Optional Feature:
- EXECUTE_MD_FASTMUL_EN defined:
  - All four multiply ops complete combinationally in IDLE using a DATA_WIDTH×DATA_WIDTH array multiply.
  - StallMD_o stays 0 and the FSM is not entered for multiplies.
  - Only divides iterate.
- Undefined: multiplies use the iterative path described above.

Decomposition:
- execute_pkg holds:
  - md_op_t enum (MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111);
  - md_state_t enum (IDLE, BUSY, DONE);
  - fwd_sel_t enum (FWD_RF, FWD_WB, FWD_MEM).
- Sub-module muldiv_unit contains the FSM, counter, accumulators and fix-up logic, and outputs result and busy.
- execute_md holds the forwarding muxes, ALU instance, PC logic and the output mux.

Test Plan:
- Forwarding/branch: ForwardAE=10, ALUResultM=0x10, RD2E=0x10, BEQ -> branchTaken_o=1, PCSrcE_o=1, no stall.
- MUL 7×−3 with DATA_WIDTH=32 -> StallMD_o high 33 cycles, then ALUResultE_o=0xFFFFFFEB for one cycle; MULH 0x80000000×0x80000000 -> 0x40000000.
- DIV −7/2 -> quotient 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with a 1-cycle stall; DIV 0x80000000/−1 -> 0x80000000, REM -> 0.
- FlushE_i asserted in the 10th BUSY cycle -> StallMD_o=0 that cycle, FSM back in IDLE; a following DIVU 100/7 returns 14.
- rst asserted mid-BUSY -> StallMD_o=0 the next cycle; with EXECUTE_MD_FASTMUL_EN defined, MULHU 0xFFFFFFFF×2 -> 1 with no stall.
